mc_control_fsm: RTL and testbench

- Parametrised multicycle MIPS control unit: main-decoder state machine, state register, ALU decoder and PC-enable logic in one block.
- Drives every datapath mux and enable of the multicycle core: PC, IR, register file, ALU and unified memory.
- Adds addi, bne and j, an optional memory-ready handshake for slow memory, and illegal-opcode trapping.

---
 rtl/mc_control_fsm.sv | 206 ++++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS control unit: main-decoder FSM, ALU decoder and PC-enable logic.
// Adds addi/bne/j, an optional memory-ready stall and illegal-opcode trapping.
module mc_control_fsm #(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter bit SUPPORT_IMM   = 1'b1,
  parameter bit SUPPORT_JUMP  = 1'b1
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       MemReq,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] PCSrc,
  output logic       PCEn,
  output logic       IllegalOp,
  output logic [3:0] State
);

  localparam int unsigned OPW = 6;

  localparam logic [OPW-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPW-1:0] OP_LW    = 6'b100011;
  localparam logic [OPW-1:0] OP_SW    = 6'b101011;
  localparam logic [OPW-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPW-1:0] OP_BNE   = 6'b000101;
  localparam logic [OPW-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPW-1:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BEQ    = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
    S_BNE    = 4'd12,
    S_TRAP   = 4'd15
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic       w_go;
  logic       w_funct_ok;
  logic [2:0] w_alu_funct;
  logic       w_memreq;
  logic       w_memwrite;
  logic       w_irwrite;
  logic       w_regwrite;
  logic       w_pcwrite;
  logic       w_branch;
  logic       w_branchne;
  logic       w_illegal;

  // Memory states advance when the access completes, or every cycle without handshake.
  assign w_go = MemReady | !MEM_HANDSHAKE;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) r_state <= S_FETCH;
    else          r_state <= w_next;
  end

  // ALU decoder for R-type function codes; unknown functs trap in DECODE.
  always_comb begin
    w_funct_ok  = 1'b1;
    w_alu_funct = ALU_ADD;
    case (Funct)
      6'b100000: w_alu_funct = ALU_ADD;
      6'b100010: w_alu_funct = ALU_SUB;
      6'b100100: w_alu_funct = ALU_AND;
      6'b100101: w_alu_funct = ALU_OR;
      6'b101010: w_alu_funct = ALU_SLT;
      default:   w_funct_ok  = 1'b0;
    endcase
  end

  always_comb begin
    w_next     = r_state;
    w_memreq   = 1'b0;
    w_memwrite = 1'b0;
    w_irwrite  = 1'b0;
    w_regwrite = 1'b0;
    w_pcwrite  = 1'b0;
    w_branch   = 1'b0;
    w_branchne = 1'b0;
    w_illegal  = 1'b0;
    IorD       = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUControl = ALU_ADD;
    PCSrc      = 2'b00;
    case (r_state)
      S_FETCH: begin
        w_memreq  = 1'b1;
        ALUSrcB   = 2'b01;
        w_irwrite = w_go;
        w_pcwrite = w_go;
        if (w_go) w_next = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (Opcode)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = w_funct_ok ? S_EXEC : S_TRAP;
          OP_BEQ:       w_next = S_BEQ;
          OP_BNE:       w_next = S_BNE;
          OP_ADDI:      w_next = SUPPORT_IMM ? S_ADDIEX : S_TRAP;
          OP_J:         w_next = SUPPORT_JUMP ? S_JUMP : S_TRAP;
          default:      w_next = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        w_next  = (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        w_memreq = 1'b1;
        IorD     = 1'b1;
        if (w_go) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        MemtoReg   = 1'b1;
        w_regwrite = 1'b1;
        w_next     = S_FETCH;
      end
      S_MEMWR: begin
        w_memreq   = 1'b1;
        IorD       = 1'b1;
        w_memwrite = 1'b1;
        if (w_go) w_next = S_FETCH;
      end
      S_EXEC: begin
        ALUSrcA    = 1'b1;
        ALUControl = w_alu_funct;
        w_next     = S_ALUWB;
      end
      S_ALUWB: begin
        RegDst     = 1'b1;
        w_regwrite = 1'b1;
        w_next     = S_FETCH;
      end
      S_BEQ, S_BNE: begin
        ALUSrcA    = 1'b1;
        ALUControl = ALU_SUB;
        PCSrc      = 2'b01;
        w_branch   = (r_state == S_BEQ);
        w_branchne = (r_state == S_BNE);
        w_next     = S_FETCH;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        w_next  = S_ADDIWB;
      end
      S_ADDIWB: begin
        w_regwrite = 1'b1;
        w_next     = S_FETCH;
      end
      S_JUMP: begin
        PCSrc     = 2'b10;
        w_pcwrite = 1'b1;
        w_next    = S_FETCH;
      end
      S_TRAP: begin
        w_illegal = 1'b1;
        w_next    = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Write strobes are killed combinationally so an asserted reset aborts any partial write.
  assign MemReq    = Reset_n & w_memreq;
  assign MemWrite  = Reset_n & w_memwrite;
  assign IRWrite   = Reset_n & w_irwrite;
  assign RegWrite  = Reset_n & w_regwrite;
  assign IllegalOp = Reset_n & w_illegal;
  assign PCEn      = Reset_n & (w_pcwrite | (w_branch & Zero) | (w_branchne & ~Zero));
  assign State     = r_state;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: two instances (full-featured, and no handshake/imm/jump),
// each driven by per-instruction step lists with randomized MemReady/Zero and mid-instruction resets.
module tb_mc_control_fsm;

  typedef struct packed {
    logic [3:0] st;
    logic       memreq, iord, memwrite, irwrite, regdst, memtoreg, regwrite, srca;
    logic [1:0] srcb;
    logic [2:0] aluc;
    logic [1:0] pcsrc;
    logic       pcen, ill;
  } obs_t;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_ADDI = 6'b001000,
                         OP_J = 6'b000010;

  logic       clk = 1'b0;
  logic       rst_n_v [2];
  logic [5:0] opc_v   [2];
  logic [5:0] fn_v    [2];
  logic       zero_v  [2];
  logic       mr_v    [2];
  obs_t       act     [2];
  bit         done    [2];

  obs_t q0[$];
  obs_t q1[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic       memreq, iord, memwrite, irwrite, regdst, memtoreg, regwrite, srca, pcen, ill;
    logic [1:0] srcb, pcsrc;
    logic [2:0] aluc;
    logic [3:0] st;
    mc_control_fsm #(
      .MEM_HANDSHAKE(g == 0),
      .SUPPORT_IMM  (g == 0),
      .SUPPORT_JUMP (g == 0)
    ) u_dut (
      .Clk(clk), .Reset_n(rst_n_v[g]), .Opcode(opc_v[g]), .Funct(fn_v[g]),
      .Zero(zero_v[g]), .MemReady(mr_v[g]),
      .MemReq(memreq), .IorD(iord), .MemWrite(memwrite), .IRWrite(irwrite),
      .RegDst(regdst), .MemtoReg(memtoreg), .RegWrite(regwrite), .ALUSrcA(srca),
      .ALUSrcB(srcb), .ALUControl(aluc), .PCSrc(pcsrc), .PCEn(pcen),
      .IllegalOp(ill), .State(st)
    );
    assign act[g] = {st, memreq, iord, memwrite, irwrite, regdst, memtoreg, regwrite, srca,
                     srcb, aluc, pcsrc, pcen, ill};
  end

  function automatic bit funct_ok(input logic [5:0] fn);
    return fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  endfunction

  // Sequence of states an instruction visits (ignoring stalls); returns step k.
  function automatic int plan(input logic [5:0] op, input logic [5:0] fn, input bit ext,
                              input int k, output int len);
    int s[5];
    s = '{0, 1, 15, 0, 0};
    len = 3;
    case (op)
      OP_LW:   begin s = '{0, 1, 2, 3, 4}; len = 5; end
      OP_SW:   begin s = '{0, 1, 2, 5, 0}; len = 4; end
      OP_R:    if (funct_ok(fn)) begin s = '{0, 1, 6, 7, 0}; len = 4; end
      OP_BEQ:  s[2] = 8;
      OP_BNE:  s[2] = 12;
      OP_ADDI: if (ext) begin s = '{0, 1, 9, 10, 0}; len = 4; end
      OP_J:    if (ext) s[2] = 11;
      default: ;
    endcase
    return s[k];
  endfunction

  // Expected control outputs in a given state, from the per-state output table.
  function automatic obs_t model(input int st, input bit mr, input bit z,
                                 input logic [5:0] fn, input bit hs);
    obs_t e;
    bit   go;
    e = '0;
    e.st = 4'(st);
    e.aluc = 3'b010;
    go = mr || !hs;
    case (st)
      0:  begin e.memreq = 1'b1; e.srcb = 2'b01; e.irwrite = go; e.pcen = go; end
      1:  e.srcb = 2'b11;
      2:  begin e.srca = 1'b1; e.srcb = 2'b10; end
      3:  begin e.memreq = 1'b1; e.iord = 1'b1; end
      4:  begin e.memtoreg = 1'b1; e.regwrite = 1'b1; end
      5:  begin e.memreq = 1'b1; e.iord = 1'b1; e.memwrite = 1'b1; end
      6:  begin
            e.srca = 1'b1;
            case (fn)
              6'b100010: e.aluc = 3'b110;
              6'b100100: e.aluc = 3'b000;
              6'b100101: e.aluc = 3'b001;
              6'b101010: e.aluc = 3'b111;
              default:   e.aluc = 3'b010;
            endcase
          end
      7:  begin e.regdst = 1'b1; e.regwrite = 1'b1; end
      8:  begin e.srca = 1'b1; e.aluc = 3'b110; e.pcsrc = 2'b01; e.pcen = z; end
      12: begin e.srca = 1'b1; e.aluc = 3'b110; e.pcsrc = 2'b01; e.pcen = !z; end
      9:  begin e.srca = 1'b1; e.srcb = 2'b10; end
      10: e.regwrite = 1'b1;
      11: begin e.pcsrc = 2'b10; e.pcen = 1'b1; end
      15: e.ill = 1'b1;
      default: ;
    endcase
    return e;
  endfunction

  task automatic push(input int idx, input obs_t e);
    if (idx == 0) q0.push_back(e);
    else          q1.push_back(e);
  endtask

  task automatic do_reset(input int idx, input int n);
    obs_t r;
    r = '0;
    r.srcb = 2'b01;
    r.aluc = 3'b010;
    repeat (n) begin
      @(posedge clk); #1;
      rst_n_v[idx] = 1'b0;
      mr_v[idx]    = 1'($urandom % 2);
      zero_v[idx]  = 1'($urandom % 2);
      push(idx, r);
    end
  endtask

  // zmode<0: random Zero. stall_st<0: random MemReady, else low for stall_n cycles in stall_st.
  task automatic do_instr(input int idx, input logic [5:0] op, input logic [5:0] fn,
                          input int zmode, input int stall_st, input int stall_n,
                          input int abort_k);
    bit hs, mr, z, fresh;
    int len, k, st, nstall, low_cnt;
    hs = (idx == 0);
    k = 0; nstall = 0; low_cnt = 0; fresh = 1'b1;
    void'(plan(op, fn, hs, 0, len));
    while (k < len) begin
      st = plan(op, fn, hs, k, len);
      if (k == abort_k && fresh) begin
        do_reset(idx, 2);
        return;
      end
      @(posedge clk); #1;
      rst_n_v[idx] = 1'b1;
      opc_v[idx]   = op;
      fn_v[idx]    = fn;
      z = (zmode < 0) ? 1'($urandom % 2) : 1'(zmode);
      if (stall_st >= 0) begin
        mr = !(st == stall_st && nstall < stall_n);
        if (!mr) nstall++;
      end else begin
        mr = (low_cnt >= 3) ? 1'b1 : ($urandom % 4 != 0);
        low_cnt = mr ? 0 : low_cnt + 1;
      end
      zero_v[idx] = z;
      mr_v[idx]   = mr;
      push(idx, model(st, mr, z, fn, hs));
      fresh = 1'b0;
      if (!((st == 0 || st == 3 || st == 5) && hs && !mr)) begin
        k++;
        fresh = 1'b1;
      end
    end
  endtask

  task automatic run(input int idx);
    logic [5:0] op, fn;
    int len, ab;
    do_reset(idx, 3);
    do_instr(idx, OP_R,   6'b100000, -1, -1, 0, 2);   // reset lands in EXEC
    do_instr(idx, OP_R,   6'b100000, -1, 99, 0, -1);
    do_instr(idx, OP_LW,  6'b000000, -1, 3, 2, -1);
    do_instr(idx, OP_SW,  6'b000000, -1, 5, 1, -1);
    do_instr(idx, OP_LW,  6'b000000, -1, 0, 2, -1);
    do_instr(idx, OP_BEQ, 6'b000000, 1, 99, 0, -1);
    do_instr(idx, OP_BEQ, 6'b000000, 0, 99, 0, -1);
    do_instr(idx, OP_BNE, 6'b000000, 1, 99, 0, -1);
    do_instr(idx, OP_BNE, 6'b000000, 0, 99, 0, -1);
    do_instr(idx, OP_J,   6'b000000, -1, 99, 0, -1);
    do_instr(idx, OP_R,   6'b000011, -1, 99, 0, -1);
    do_instr(idx, OP_ADDI, 6'b000000, -1, 99, 0, -1);
    for (int i = 0; i < 5; i++)
      do_instr(idx, OP_R, 6'b100000 | 6'(i == 1 ? 2 : i == 2 ? 4 : i == 3 ? 5 : i == 4 ? 10 : 0),
               -1, 99, 0, -1);
    for (int n = 0; n < 150; n++) begin
      case ($urandom % 9)
        0: op = OP_LW;   1: op = OP_SW;   2, 3: op = OP_R;
        4: op = OP_BEQ;  5: op = OP_BNE;  6: op = OP_ADDI;
        7: op = OP_J;    default: op = 6'($urandom);
      endcase
      if ($urandom % 4 != 0) begin
        case ($urandom % 5)
          0: fn = 6'b100000; 1: fn = 6'b100010; 2: fn = 6'b100100;
          3: fn = 6'b100101; default: fn = 6'b101010;
        endcase
      end else fn = 6'($urandom);
      void'(plan(op, fn, idx == 0, 0, len));
      ab = ($urandom % 12 == 0) ? int'($urandom_range(1, len - 1)) : -1;
      do_instr(idx, op, fn, -1, -1, 0, ab);
    end
    done[idx] = 1'b1;
  endtask

  // Monitor: every cycle each DUT presents a control vector; pop and compare.
  always @(negedge clk) begin
    obs_t e;
    bit   have;
    for (int i = 0; i < 2; i++) begin
      have = 1'b0;
      if (i == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
      if (i == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
      if (have) begin
        n_checks++;
        if (act[i] === e) n_pass++;
        else $display("FAIL ctrl dut%0d t=%0t: act st=%0d vec=%h, exp st=%0d vec=%h",
                      i, $time, act[i].st, act[i], e.st, e);
      end else if (!done[i]) begin
        n_checks++;
        $display("FAIL underflow dut%0d t=%0t: act no expectation, exp one per cycle", i, $time);
      end
    end
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst_n_v[i] = 1'b0; opc_v[i] = '0; fn_v[i] = '0;
      zero_v[i] = 1'b0; mr_v[i] = 1'b1; done[i] = 1'b0;
    end
    fork
      run(0);
      run(1);
    join
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (q0.size() == 0 && q1.size() == 0) n_pass++;
    else $display("FAIL drain: act q0=%0d q1=%0d entries left, exp 0", q0.size(), q1.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: act still running at t=%0t, exp finished", $time);
    $fatal(1);
  end

endmodule
